// File: rtl/cdcc_pkg.sv
// Shared types for the dilated convolution datapath.
// Used by the tap buffer and the downstream dot product.
package cdcc_pkg;

    localparam int W_DEF = 16;
    localparam int TAPS  = 4;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD1,
        RD2,
        RD3,
        LOAD
    } state_t;

endpackage

// File: rtl/tap_ram.sv
// Single-port history store with synchronous read.
// One write or one read per cycle; maps onto block RAM.
module tap_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 7,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dilated_tap_buffer.sv
// Circular activation history producing a 4-tap dilated window.
// One sample accepted per 5 cycles; taps read back one per cycle.
module dilated_tap_buffer
    import cdcc_pkg::*;
#(
    parameter  int W        = W_DEF,
    parameter  int DILATION = 2,
    localparam int DEPTH    = 3 * DILATION + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic signed [W-1:0]          in_sample,
    input  logic                         in_v,
    output logic                         in_ready,
    output logic signed [TAPS-1:0][W-1:0] a,
    output logic                         out_v
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wp;
    logic [AW-1:0] caddr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  tap0;
    logic [W-1:0]  tap1;
    logic [W-1:0]  tap2;
    logic          clr_pend;
    logic          accept;

    // k*DILATION < DEPTH, so one conditional add of DEPTH corrects the wrap
    function automatic logic [AW-1:0] back(input logic [AW-1:0] p,
                                           input int k);
        logic [AW:0] off;
        logic [AW:0] base;
        off  = (AW+1)'(k * DILATION);
        base = {1'b0, p};
        if (base >= off) begin
            return AW'(base - off);
        end
        return AW'(base + (AW+1)'(DEPTH) - off);
    endfunction

    tap_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_addr  = wp;
        ram_wdata = in_sample;
        accept    = 1'b0;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = caddr;
                ram_wdata = '0;
                if (caddr == LAST) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                end else if (in_v) begin
                    accept   = 1'b1;
                    ram_we   = 1'b1;
                    state_nx = RD1;
                end
            end
            RD1: begin
                ram_addr = back(wp, 1);
                state_nx = RD2;
            end
            RD2: begin
                ram_addr = back(wp, 2);
                state_nx = RD3;
            end
            RD3: begin
                ram_addr = back(wp, 3);
                state_nx = LOAD;
            end
            LOAD: begin
                // a clear requested mid-window starts right after the pulse
                state_nx = (clr_pend || clr) ? CLEAR : IDLE;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            caddr    <= '0;
            wp       <= '0;
            tap0     <= '0;
            tap1     <= '0;
            tap2     <= '0;
            a        <= '0;
            out_v    <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            out_v <= 1'b0;
            if (state == CLEAR) begin
                caddr <= (caddr == LAST) ? '0 : caddr + AW'(1);
                if (caddr == LAST) begin
                    wp <= '0;
                end
            end
            if (state_nx == CLEAR) begin
                clr_pend <= 1'b0;
            end else if (clr && state != IDLE && state != CLEAR) begin
                clr_pend <= 1'b1;
            end
            if (accept) begin
                tap0 <= in_sample;
            end
            if (state == RD2) begin
                tap1 <= ram_rdata;
            end
            if (state == RD3) begin
                tap2 <= ram_rdata;
            end
            if (state == LOAD) begin
                a     <= {ram_rdata, tap2, tap1, tap0};
                out_v <= 1'b1;
                wp    <= (wp == LAST) ? '0 : wp + AW'(1);
            end
        end
    end

endmodule
